// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Lane masks: bytes of an access that land in the first or the spill word.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_RESP
  } state_e;

  function automatic logic [2:0] size_bytes(logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] span(logic [1:0] size, logic [1:0] off);
    logic [7:0] m;
    case (size)
      SIZE_B:  m = 8'b0000_0001;
      SIZE_H:  m = 8'b0000_0011;
      default: m = 8'b0000_1111;
    endcase
    return m << off;
  endfunction

  function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] off);
    logic [7:0] m;
    m = span(size, off);
    return m[3:0];
  endfunction

  function automatic logic [3:0] spill_mask(logic [1:0] size, logic [1:0] off);
    logic [7:0] m;
    m = span(size, off);
    return m[7:4];
  endfunction

  function automatic logic crosses(logic [1:0] size, logic [1:0] off);
    return ({1'b0, off} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane merge for stores and byte gather/extend for loads.
// Build option LSU_MISALIGN_EN adds the spill-word (second access) lanes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
`ifdef LSU_MISALIGN_EN
  input  logic        hi_i,
`endif
  input  logic        uns_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] buf_i,
  output logic [31:0] wdata_o,
  output logic [31:0] buf_o,
  output logic [31:0] ext_o
);

  logic [3:0] mask;
  logic [1:0] k;

  // Access byte k sits at lane (off+k) mod 4 in either word.
  always_comb begin
    wdata_o = rdata_i;
    buf_o   = buf_i;
    k       = 2'd0;
    mask    = lane_mask(size_i, off_i);
`ifdef LSU_MISALIGN_EN
    if (hi_i) mask = spill_mask(size_i, off_i);
`endif
    for (int l = 0; l < 4; l++) begin
      k = 2'(l) - off_i;
      if (mask[l]) begin
        wdata_o[8*l +: 8]     = wdata_i[{k, 3'b000} +: 8];
        buf_o[{k, 3'b000} +: 8] = rdata_i[8*l +: 8];
      end
    end
  end

  always_comb begin
    case (size_i)
      SIZE_B:  ext_o = {{24{~uns_i & buf_i[7]}}, buf_i[7:0]};
      SIZE_H:  ext_o = {{16{~uns_i & buf_i[15]}}, buf_i[15:0]};
      default: ext_o = buf_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: byte/half/word requests to a word-wide memory port.
// Define LSU_MISALIGN_EN to split word-crossing accesses instead of faulting.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, buf_q;
  logic [31:0] buf_n, ext;
  logic        acc, bad, hi;

`ifdef LSU_MISALIGN_EN
  assign bad = (req_size == SIZE_X);
  assign hi  = (state_q == ST_ACC1);
`else
  assign bad = (req_size == SIZE_X)
             | ((req_size == SIZE_H) & req_addr[0])
             | ((req_size == SIZE_W) & (|req_addr[1:0]));
  assign hi  = 1'b0;
`endif

  assign acc = (state_q == ST_ACC0) | (state_q == ST_ACC1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = bad ? ST_RESP : ST_ACC0;
`ifdef LSU_MISALIGN_EN
      ST_ACC0: state_d = crosses(size_q, addr_q[1:0]) ? ST_ACC1 : ST_RESP;
`else
      ST_ACC0: state_d = ST_RESP;
`endif
      ST_ACC1: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
`ifdef LSU_MISALIGN_EN
    .hi_i    (hi),
`endif
    .uns_i   (uns_q),
    .rdata_i (mem_rdata),
    .wdata_i (wdata_q),
    .buf_i   (buf_q),
    .wdata_o (mem_wdata),
    .buf_o   (buf_n),
    .ext_o   (ext)
  );

  // Second word wraps past the top of the address space.
  assign mem_addr = {addr_q[31:2] + {29'd0, hi}, 2'b00};
  assign mem_we   = we_q & acc & ~rst;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid & ~we_q & ~err_q) ? ext : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_B;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= bad;
        buf_q   <= 32'd0;
      end
      if (acc && !we_q) buf_q <= buf_n;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu against a byte-array memory model.
// Honours LSU_MISALIGN_EN for the expected handling of misaligned requests.
module tb_lsu;

`ifdef LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tmem [16];
  logic [7:0]  rmem [64];
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_dat;
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // 64-byte memory, aliased across the whole address space.
  assign mem_rdata = tmem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (ld_en) begin
      tmem[ld_idx] <= ld_dat;
    end else if (mem_we) begin
      tmem[mem_addr[5:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(int i);
    return {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
  endfunction

  function automatic logic [31:0] ref_load(
    logic [31:0] a, logic [1:0] s, logic u);
    logic [31:0] v;
    int n;
    v = 0;
    n = nbytes(s);
    for (int k = 0; k < n; k++) v[8*k +: 8] = rmem[(a + k) % 64];
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic xact(input logic we, input logic [1:0] s,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd);
    int lat, w0, n, lat_e, wr_e;
    logic err_e;
    logic [31:0] rd_e;
    @(negedge clk);
    check("ready", req_ready, 1);
    req_valid = 1; req_we = we; req_size = s;
    req_unsigned = u; req_addr = a; req_wdata = wd;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    n = (s == 2'd3) ? 1 : nbytes(s);
    err_e = (s == 2'd3) || (!MIS && (a % n) != 0);
    if (err_e) begin
      lat_e = 1; wr_e = 0; rd_e = 0;
    end else begin
      lat_e = ((a % 4) + n > 4) ? 3 : 2;
      wr_e = we ? lat_e - 1 : 0;
      rd_e = we ? 32'd0 : ref_load(a, s, u);
    end
    rd = resp_rdata;
    check("latency", lat, lat_e);
    check("valid", resp_valid, 1);
    check("err", resp_err, err_e);
    check("rdata", resp_rdata, rd_e);
    check("writes", wr_cnt - w0, wr_e);
    if (we && !err_e)
      for (int k = 0; k < n; k++) rmem[(a + k) % 64] = wd[8*k +: 8];
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          w0;

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    ld_en = 1; ld_idx = 0; ld_dat = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_idx = 4'(i);
      ld_dat = (i == 0) ? 32'h4433_2211 :
               (i == 1) ? 32'h8877_6655 : $urandom;
      for (int b = 0; b < 4; b++) rmem[4*i+b] = ld_dat[8*b +: 8];
    end
    @(negedge clk);
    ld_en = 0;
    check("rst_valid", resp_valid, 0);
    check("rst_we", mem_we, 0);
    rst = 0;
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_err", resp_err, 0);

    xact(0, 2'd2, 0, 32'h0, 0, rd);
    check("lw0", rd, 32'h4433_2211);
    xact(0, 2'd0, 0, 32'h7, 0, rd);
    check("lb7", rd, 32'hFFFF_FF88);
    xact(0, 2'd0, 1, 32'h7, 0, rd);
    check("lbu7", rd, 32'h0000_0088);
    xact(0, 2'd1, 0, 32'h2, 0, rd);
    check("lh2", rd, 32'h0000_4433);
    xact(1, 2'd1, 0, 32'h2, 32'h0000_AABB, rd);
    @(negedge clk);
    check("sh_w0", tmem[0], 32'hAABB_2211);
    check("sh_w1", tmem[1], 32'h8877_6655);
    xact(0, 2'd2, 0, 32'h3, 0, rd);
    xact(1, 2'd2, 0, 32'h2, 32'hDDCC_BBAA, rd);
    xact(0, 2'd1, 0, 32'hFFFF_FFFF, 0, rd);
    xact(1, 2'd3, 0, 32'h8, 32'h1234_5678, rd);
    xact(0, 2'd3, 0, 32'h8, 0, rd);

    for (int t = 0; t < 120; t++) begin
      rs = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      xact(1'($urandom), rs, 1'($urandom),
           {$urandom_range(0, 3) == 0 ? 26'h3FF_FFFF : 26'd0,
            6'($urandom)}, $urandom, rd);
    end

    // Reset during the first access cycle of an aligned store.
    @(negedge clk);
    w0 = wr_cnt;
    req_valid = 1; req_we = 1; req_size = 2'd2;
    req_addr = 32'h0; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rst = 1; req_valid = 0;
    @(negedge clk);
    check("abort_ready_rst", req_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("abort_novalid", resp_valid, 0);
      @(negedge clk);
    end
    check("abort_writes", wr_cnt - w0, 0);
    check("abort_w0", tmem[0], ref_word(0));

    xact(0, 2'd2, 0, 32'h4, 0, rd);
    for (int i = 0; i < 16; i++) check("final_mem", tmem[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the word-organised data `memory`. It accepts byte, halfword and word load/store requests at byte addresses and converts them into whole-word accesses on `memory`'s single port. Stores use read-modify-write through `memory`'s combinational read. Loads return sign- or zero-extended data. Misaligned accesses that cross a word boundary are split into two sequential word accesses.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: LSU idle and able to accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` input 1: zero-extend load data (LBU/LHU); ignored for stores and word loads.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: request rejected, valid with `resp_valid`.
- `mem_we` output 1: to `memory` `we`.
- `mem_addr` output 32: word-aligned address to `memory` (bits [1:0] = 0).
- `mem_wdata` output 32: merged word to `memory`.
- `mem_rdata` input 32: combinational read data from `memory`.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch the request and go to ACC0.
  - If `req_size`=11, go to RESP with the error flag set instead.
- ACC0:
  - `mem_addr` = {addr[31:2],2'b00}.
  - Load: capture the required bytes of `mem_rdata`.
  - Store: drive `mem_wdata` = `mem_rdata` with the addressed byte lanes replaced by `req_wdata` bytes (little-endian), and assert `mem_we`.
  - If the access crosses a word boundary, go to ACC1; otherwise go to RESP.
- ACC1:
  - `mem_addr` = {addr[31:2]+1,2'b00}, wrapping 0xFFFFFFFC→0x00000000.
  - Remaining bytes are read or merged the same way as in ACC0.
  - Go to RESP.
- RESP:
  - `resp_valid`=1 for this one cycle; no backpressure.
  - `resp_rdata` = assembled load bytes, sign-extended from bit 7/15 unless `req_unsigned`.
  - Go to IDLE.
- A word boundary is crossed by: halfword at offset 3; word at offset 1, 2 or 3.
- `mem_we` = store & (ACC0|ACC1) & ~rst. A reset asserted during an access cycle suppresses that write.
- `mem_we`=0 in IDLE and RESP. `mem_addr`/`mem_wdata` are don't-care when `mem_we`=0.
- Reset (any state, including mid-split): state←IDLE; `resp_valid`, `resp_err`, `resp_rdata`, captured bytes ← 0. No response is ever produced for the aborted request.
- A split store that is aborted after ACC0 leaves word0 written and word1 untouched. This is accepted behaviour.

## Timing
- Request accepted at edge T; `req_ready` is low from T until the response cycle ends.
- Aligned or non-crossing access: ACC0 in cycle T+1, `resp_valid` in cycle T+2.
- Crossing access: ACC0 in T+1, ACC1 in T+2, `resp_valid` in T+3.
- Error: `resp_valid` with `resp_err`=1 in T+1; no memory access.
- Back-to-back issue: next request is accepted at the edge ending the RESP cycle. Throughput is one aligned access per 3 cycles.

## Configuration
- `LSU_MISALIGN_EN` defined:
  - Misaligned accesses are handled.
  - Non-crossing accesses use ACC0 only; crossing accesses use ACC0+ACC1.
- Undefined:
  - Any misaligned access (halfword with addr[0]=1; word with addr[1:0]≠0) goes IDLE→RESP with `resp_err`=1 and no memory write.
  - ACC1 and its byte-assembly logic are not compiled.

## Structure
- `lsu_pkg`: `req_size` encodings (SIZE_B, SIZE_H, SIZE_W), state enum, and a byte-lane mask function (size, offset → 4-bit mask).
- Sub-module `lsu_align`: combinational byte-lane merge for stores, plus extract/extend for loads, shared by ACC0 and ACC1.

## Test plan
Memory is preloaded with word 0x000=0x44332211 and word 0x004=0x88776655.
- LW 0x000 accepted at T → `resp_valid` at T+2, `resp_rdata`=0x44332211, `resp_err`=0.
- LB 0x007 → 0xFFFFFF88; LBU 0x007 → 0x00000088; LH 0x002 → 0x00004433.
- SH 0x002, wdata 0x0000AABB → word 0x000=0xAABB2211, word 0x004 unchanged, response at T+2 with `resp_rdata`=0.
- With `LSU_MISALIGN_EN`:
  - LW 0x003 → 0x77665544 at T+3.
  - SW 0x002, wdata 0xDDCCBBAA → 0x000=0xBBAA2211, 0x004=0x8877DDCC.
  - Without the macro, both requests give `resp_err`=1 at T+1 and memory is unchanged.
- `req_size`=11 → `resp_err`=1 at T+1, `mem_we` never asserted.
- SW 0x000 with `rst` asserted in the ACC0 cycle → word 0x000 stays 0x44332211, no `resp_valid`, `req_ready`=1 the cycle after reset deasserts.
